reg_display_driver: RTL

Board-level front panel for the register file's debug port. Steps the 3-bit `showAddress` through registers 0-7 from a debounced push-button. Takes back the 32-bit `display` word and shows one 16-bit half of it as four hex digits on a multiplexed, active-low 7-segment display. Sits between the board I/O pins and the register file's `showAddress`/`display` pair.

---
 rtl/board_io_pkg.sv | 14 +
 rtl/btn_debounce.sv | 52 +++++
 rtl/reg_display_driver.sv | 83 ++++++++
 3 files changed

// File: rtl/board_io_pkg.sv
// Shared board front-panel constants: hex-to-segment table, blank codes, default timings.
package board_io_pkg;
  localparam int REFRESH_DIV_DEF     = 50000;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // gfedcba, active-low; entry 15 (F) on the left, entry 0 on the right
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, counter debounce, rising-edge pulse.
module btn_debounce
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DC_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d, s2_q, s2_d;
  logic          stb_q, stb_d, stb_dly_q, stb_dly_d;
  logic [CW-1:0] dcnt_q, dcnt_d;

  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    stb_d     = stb_q;
    stb_dly_d = stb_q;
    dcnt_d    = dcnt_q;
    if (s2_q == stb_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DC_MAX) begin
      stb_d  = s2_q;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      stb_q     <= 1'b0;
      stb_dly_q <= 1'b0;
      dcnt_q    <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stb_q     <= stb_d;
      stb_dly_q <= stb_dly_d;
      dcnt_q    <= dcnt_d;
    end
  end

  assign rise = stb_q & ~stb_dly_q;
endmodule

// File: rtl/reg_display_driver.sv
// Front panel for the register file debug port: button steps showAddress,
// one half of the returned word is scanned onto a 4-digit active-low 7-seg display.
module reg_display_driver
  import board_io_pkg::*;
#(
  parameter int REFRESH_DIV     = REFRESH_DIV_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic        clock_in,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        sw_page,
  input  logic [31:0] display,
  output logic [2:0]  showAddress,
  output logic [3:0]  an,
  output logic [7:0]  seg
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);

  logic          rise, tick;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    k_q, k_d;
  logic [2:0]    addr_q, addr_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic [15:0]   snap_half_q, snap_half_d, half_sh;
  logic          snap_page_q, snap_page_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk     (clock_in),
    .rst     (rst),
    .btn_raw (btn_next),
    .rise    (rise)
  );

  assign tick = (div_q == DIV_MAX);

  always_comb begin
    div_d       = tick ? '0 : div_q + 1'b1;
    k_d         = k_q;
    an_d        = an_q;
    seg_d       = seg_q;
    snap_half_d = snap_half_q;
    snap_page_d = snap_page_q;
    addr_d      = rise ? addr_q + 3'd1 : addr_q;
    half_sh     = snap_half_q >> {k_q, 2'b00};
    if (tick) begin
      k_d   = k_q + 2'd1;
      an_d  = ~(4'b0001 << k_q);
      seg_d = {~((k_q == 2'd3) && snap_page_q), HEX_SEG[half_sh[3:0]]};
      // reload only at the frame boundary so a frame never mixes two words
      if (k_q == 2'd3) begin
        snap_page_d = sw_page;
        snap_half_d = sw_page ? display[31:16] : display[15:0];
      end
    end
  end

  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      k_q         <= 2'd0;
      addr_q      <= 3'd0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
      snap_half_q <= 16'h0000;
      snap_page_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      snap_half_q <= snap_half_d;
      snap_page_q <= snap_page_d;
    end
  end

  assign showAddress = addr_q;
  assign an          = an_q;
  assign seg         = seg_q;
endmodule
